// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: debounced RUN/HALT and STEP buttons drive the CPU clock enable.
// Define CPU_RUN_CTRL_BKPT_EN to build the PC breakpoint comparator and BREAK state.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_run_n,
    input  logic        btn_step_n,
    input  logic [31:0] pc,
    input  logic [31:0] bkpt_addr,
    input  logic        bkpt_valid,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        halted,
    output logic        bkpt_hit,
    output logic [31:0] ce_count
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DB_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } state_e;

    // Index 0 is RUN/HALT, index 1 is STEP.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       press_q, press_d;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              bkpt_hit_q, bkpt_hit_d;
    logic [31:0]       ce_count_q, ce_count_d;
    logic              run_press, step_press;
    logic              match;

    assign btn_raw = {btn_step_n, btn_run_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            stable_q    <= 2'b11;
            press_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        press_d  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = ~sync2_q[i];  // only a new low level counts as a press
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign run_press  = press_q[0];
    assign step_press = press_q[1];

`ifdef CPU_RUN_CTRL_BKPT_EN
    logic bkpt_mask_q, bkpt_mask_d;

    assign match = (state_q == StRun) && bkpt_valid && (pc == bkpt_addr) && !bkpt_mask_q;

    // Mask stops a resumed CPU from re-breaking on the address it is parked at.
    always_comb begin
        bkpt_mask_d = bkpt_mask_q;
        if (state_q == StBreak && state_d != StBreak) begin
            bkpt_mask_d = 1'b1;
        end else if (pc != bkpt_addr) begin
            bkpt_mask_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bkpt_mask_q <= 1'b0;
        end else begin
            bkpt_mask_q <= bkpt_mask_d;
        end
    end
`else
    logic unused_bkpt;

    assign match       = 1'b0;
    assign unused_bkpt = ^{pc, bkpt_addr, bkpt_valid};
`endif

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        bkpt_hit_d = 1'b0;
        unique case (state_q)
            StHalt, StBreak: begin
                if (run_press) begin
                    state_d = StRun;
                end else if (step_press) begin
                    state_d    = StStep;
                    step_cnt_d = STEP_LOAD;
                end
            end
            StRun: begin
                if (run_press) begin
                    state_d = StHalt;
                end else if (match) begin
                    state_d    = StBreak;
                    bkpt_hit_d = 1'b1;
                end
            end
            StStep: begin
                if (step_cnt_q == '0) begin
                    state_d = StHalt;
                end else begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        cpu_ce     = ((state_q == StRun) && !match) || (state_q == StStep);
        ce_count_d = ce_count_q;
        if (cpu_ce) begin
            ce_count_d = ce_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHalt;
            step_cnt_q <= '0;
            bkpt_hit_q <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            bkpt_hit_q <= bkpt_hit_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign state    = state_q;
    assign halted   = (state_q == StHalt) || (state_q == StBreak);
    assign bkpt_hit = bkpt_hit_q;
    assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected state transitions,
// a monitor pops and compares them whenever the DUT state changes.
module tb_cpu_run_ctrl;

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_run_n;
    logic        btn_step_n;
    logic [31:0] pc_m = 32'd0;
    logic [31:0] bkpt_addr;
    logic        bkpt_valid;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        halted;
    logic        bkpt_hit;
    logic [31:0] ce_count;

    logic        pc_clr = 1'b0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          hit_cnt = 0;
    int          k, k2;
    logic [31:0] c_exp;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
        int          cy;     // -1: cycle not checked
        int          steps;  // -1: enable count of the left STEP episode not checked
        logic        hit;
    } exp_t;

    exp_t exp_q[$];

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_run_n (btn_run_n),
        .btn_step_n(btn_step_n),
        .pc        (pc_m),
        .bkpt_addr (bkpt_addr),
        .bkpt_valid(bkpt_valid),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .halted    (halted),
        .bkpt_hit  (bkpt_hit),
        .ce_count  (ce_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CPU fetch model: PC advances by 4 on each enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) pc_m <= 32'd0;
        else if (cpu_ce) pc_m <= pc_m + 32'd4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [31:0] cnt, input int cy,
                        input int steps, input logic hit);
        exp_t e;
        e.st = st; e.cnt = cnt; e.cy = cy; e.steps = steps; e.hit = hit;
        exp_q.push_back(e);
    endtask

    task automatic start_press(input bit run, input bit step, output int kk);
        @(negedge clk);
        kk = cyc;
        if (run) btn_run_n = 1'b0;
        if (step) btn_step_n = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        btn_run_n  = 1'b1;
        btn_step_n = 1'b1;
    endtask

    task automatic settle();
        repeat (16) @(negedge clk);
    endtask

    // Monitor: every state change consumes one expectation.
    initial begin : monitor
        logic [1:0] prev;
        int         step_ce;
        exp_t       e;
        step_ce = 0;
        wait (mon_en);
        prev = state;
        forever begin
            @(negedge clk);
            if (state !== prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_transition: state %0d -> %0d at cycle %0d, expected none",
                             prev, state, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("trans_state", 32'(state), 32'(e.st));
                    chk("trans_ce_count", ce_count, e.cnt);
                    chk("trans_bkpt_hit", 32'(bkpt_hit), 32'(e.hit));
                    if (e.cy >= 0) chk("trans_cycle", 32'(cyc), 32'(e.cy));
                    if (e.steps >= 0 && prev == S_STEP) chk("step_ce_cycles", 32'(step_ce), 32'(e.steps));
                end
                step_ce = 0;
                prev    = state;
            end
            if (state == S_STEP && cpu_ce) step_ce++;
            if (bkpt_hit) hit_cnt++;
        end
    end

    initial begin : stimulus
        btn_run_n  = 1'b1;
        btn_step_n = 1'b1;
        bkpt_addr  = 32'h20;
        bkpt_valid = 1'b0;
        rst_n      = 1'b1;
        c_exp      = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle with both buttons released
        repeat (20) @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_HALT));
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_ce_count", ce_count, 32'd0);
        chk("rst_bkpt_hit", 32'(bkpt_hit), 32'd0);

        // 3-cycle glitch is shorter than the debounce window
        start_press(0, 1, k);
        hold(3);
        settle();
        chk("glitch_no_press", 32'(state), 32'(S_HALT));

        // Single STEP press: 3 enable cycles
        start_press(0, 1, k);
        push(S_STEP, c_exp, k + 7, -1, 1'b0);
        push(S_HALT, c_exp + 32'd3, k + 10, 3, 1'b0);
        c_exp += 32'd3;
        hold(10);
        settle();
        chk("step_ce_count", ce_count, c_exp);

        // RUN then HALT
        start_press(1, 0, k);
        push(S_RUN, c_exp, k + 7, -1, 1'b0);
        hold(10);
        settle();
        chk("run_ce_high", 32'(cpu_ce), 32'd1);
        start_press(1, 0, k2);
        push(S_HALT, c_exp + 32'(k2 - k), k2 + 7, -1, 1'b0);
        c_exp += 32'(k2 - k);
        hold(10);
        settle();
        chk("halt_count_frozen", ce_count, c_exp);

        // Breakpoint at 0x20 with PC starting from 0
        @(negedge clk) pc_clr = 1'b1;
        @(negedge clk) pc_clr = 1'b0;
        bkpt_valid = 1'b1;
`ifdef CPU_RUN_CTRL_BKPT_EN
        start_press(1, 0, k);
        push(S_RUN, c_exp, k + 7, -1, 1'b0);
        push(S_BREAK, c_exp + 32'd8, k + 16, -1, 1'b1);
        c_exp += 32'd8;
        hold(10);
        settle();
        chk("bkpt_pc_held", pc_m, 32'h20);
        chk("bkpt_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("bkpt_halted", 32'(halted), 32'd1);
        chk("bkpt_hit_pulses", 32'(hit_cnt), 32'd1);
        start_press(1, 0, k);
        push(S_RUN, c_exp, k + 7, -1, 1'b0);
        hold(10);
        settle();
        chk("resume_past_bkpt", 32'(pc_m > 32'h20), 32'd1);
        chk("resume_no_rehit", 32'(hit_cnt), 32'd1);
        start_press(1, 0, k2);
        push(S_HALT, c_exp + 32'(k2 - k), k2 + 7, -1, 1'b0);
        c_exp += 32'(k2 - k);
        hold(10);
        settle();
`else
        start_press(1, 0, k);
        push(S_RUN, c_exp, k + 7, -1, 1'b0);
        hold(10);
        settle();
        chk("nobkpt_still_run", 32'(state), 32'(S_RUN));
        start_press(1, 0, k2);
        push(S_HALT, c_exp + 32'(k2 - k), k2 + 7, -1, 1'b0);
        c_exp += 32'(k2 - k);
        hold(10);
        settle();
        chk("nobkpt_pc_advanced", pc_m, 32'((k2 - k) * 4));
        chk("nobkpt_no_hit", 32'(hit_cnt), 32'd0);
`endif
        bkpt_valid = 1'b0;

        // Both buttons together: RUN/HALT wins
        start_press(1, 1, k);
        push(S_RUN, c_exp, k + 7, -1, 1'b0);
        hold(10);
        settle();
        start_press(1, 0, k2);
        push(S_HALT, c_exp + 32'(k2 - k), k2 + 7, -1, 1'b0);
        c_exp += 32'(k2 - k);
        hold(10);
        settle();

        // RUN press landing mid-STEP is ignored
        start_press(0, 1, k);
        push(S_STEP, c_exp, k + 7, -1, 1'b0);
        push(S_HALT, c_exp + 32'd3, k + 10, 3, 1'b0);
        c_exp += 32'd3;
        repeat (2) @(negedge clk);
        btn_run_n = 1'b0;
        hold(8);
        settle();
        chk("press_in_step_ignored", 32'(state), 32'(S_HALT));
        chk("press_in_step_count", ce_count, c_exp);

        // Reset during the 2nd STEP enable cycle
        start_press(0, 1, k);
        push(S_STEP, c_exp, k + 7, -1, 1'b0);
        push(S_HALT, 32'd0, -1, -1, 1'b0);
        hold(5);
        repeat (3) @(negedge clk);
        chk("mid_step_state", 32'(state), 32'(S_STEP));
        chk("mid_step_count", ce_count, c_exp + 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'(S_HALT));
        chk("async_rst_count", ce_count, 32'd0);
        chk("async_rst_cpu_ce", 32'(cpu_ce), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c_exp = 32'd0;
        settle();

        // Full STEP after reset
        start_press(0, 1, k);
        push(S_STEP, c_exp, k + 7, -1, 1'b0);
        push(S_HALT, c_exp + 32'd3, k + 10, 3, 1'b0);
        c_exp += 32'd3;
        hold(10);
        settle();
        chk("post_rst_step_count", ce_count, c_exp);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
